blk_stream_arbiter: RTL and testbench

- Block-granular round-robin arbiter that shares one downstream compression datapath (find_emax onward) between two valid/ready floating-point streams.
- Grants one requester for exactly BLOCK_LEN beats, so the datapath never sees values from two sources within one block.
- Output is registered and tagged with source id and last-of-block.
- Sits between per-channel input queues and find_emax.

---
 rtl/blk_stream_arbiter.sv | 72 +++++++
 tb/tb_blk_stream_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/blk_stream_arbiter.sv
// blk_stream_arbiter: block-granular round-robin arbiter merging two fp streams into one registered output.
module blk_stream_arbiter #(
  parameter int DW = 64,
  parameter int BLOCK_LEN = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] s0_fp_data,
  input  logic          s0_fp_valid,
  output logic          s0_fp_ready,
  input  logic [DW-1:0] s1_fp_data,
  input  logic          s1_fp_valid,
  output logic          s1_fp_ready,
  output logic [DW-1:0] m_fp_data,
  output logic          m_fp_valid,
  input  logic          m_fp_ready,
  output logic          m_fp_id,
  output logic          m_fp_last,
  output logic          busy,
  output logic          grant
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic rr_ptr, out_free, sg_valid, acc, pop, last_beat, g_nxt;
  logic [DW-1:0] sg_data;
  assign out_free = !m_fp_valid || m_fp_ready;
  assign s0_fp_ready = state == BUSY && !grant && out_free;
  assign s1_fp_ready = state == BUSY && grant && out_free;
  assign sg_valid = grant ? s1_fp_valid : s0_fp_valid;
  assign sg_data = grant ? s1_fp_data : s0_fp_data;
  assign acc = state == BUSY && sg_valid && out_free;
  assign pop = m_fp_valid && m_fp_ready;
  assign last_beat = cnt == CW'(BLOCK_LEN - 1);
  // Contention resolves to rr_ptr; a lone requester wins outright.
  assign g_nxt = (s0_fp_valid && s1_fp_valid) ? rr_ptr : s1_fp_valid;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      rr_ptr <= 1'b0;
      m_fp_data <= '0;
      m_fp_valid <= 1'b0;
      m_fp_id <= 1'b0;
      m_fp_last <= 1'b0;
      busy <= 1'b0;
      grant <= 1'b0;
    end else begin
      if (pop) m_fp_valid <= 1'b0;
      if (state == IDLE) begin
        if (s0_fp_valid || s1_fp_valid) begin
          grant <= g_nxt;
          busy <= 1'b1;
          state <= BUSY;
          cnt <= '0;
        end
      end else if (acc) begin
        m_fp_data <= sg_data;
        m_fp_id <= grant;
        m_fp_last <= last_beat;
        m_fp_valid <= 1'b1;
        cnt <= last_beat ? '0 : cnt + CW'(1);
        if (last_beat) begin
          rr_ptr <= ~grant;
          busy <= 1'b0;
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_blk_stream_arbiter.sv
// tb_blk_stream_arbiter: directed scenario tests for blk_stream_arbiter (BLOCK_LEN=4 and BLOCK_LEN=1 builds).
module tb_blk_stream_arbiter;
  localparam int DW = 64;
  logic clk = 0, reset = 0;
  logic [DW-1:0] s0_data, s1_data, m_data;
  logic s0_valid, s0_ready, s1_valid, s1_ready, m_valid, m_ready, m_id, m_last, busy, grant;
  logic [DW-1:0] t_s0_data, t_s1_data, t_m_data;
  logic t_s0_valid, t_s0_ready, t_s1_valid, t_s1_ready, t_m_valid, t_m_ready, t_m_id, t_m_last, t_busy, t_grant;
  int errs = 0, checks = 0;
  logic a0, a1;
  logic [DW+1:0] q[$];

  always #5 clk = ~clk;

  blk_stream_arbiter #(.DW(DW), .BLOCK_LEN(4), .CW(8)) dut (
    .clk(clk), .reset(reset),
    .s0_fp_data(s0_data), .s0_fp_valid(s0_valid), .s0_fp_ready(s0_ready),
    .s1_fp_data(s1_data), .s1_fp_valid(s1_valid), .s1_fp_ready(s1_ready),
    .m_fp_data(m_data), .m_fp_valid(m_valid), .m_fp_ready(m_ready),
    .m_fp_id(m_id), .m_fp_last(m_last), .busy(busy), .grant(grant));

  blk_stream_arbiter #(.DW(DW), .BLOCK_LEN(1), .CW(1)) dut1 (
    .clk(clk), .reset(reset),
    .s0_fp_data(t_s0_data), .s0_fp_valid(t_s0_valid), .s0_fp_ready(t_s0_ready),
    .s1_fp_data(t_s1_data), .s1_fp_valid(t_s1_valid), .s1_fp_ready(t_s1_ready),
    .m_fp_data(t_m_data), .m_fp_valid(t_m_valid), .m_fp_ready(t_m_ready),
    .m_fp_id(t_m_id), .m_fp_last(t_m_last), .busy(t_busy), .grant(t_grant));

  task automatic step();
    @(negedge clk);
    a0 = s0_valid && s0_ready;
    a1 = s1_valid && s1_ready;
    if (m_valid && m_ready) q.push_back({m_id, m_last, m_data});
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 0;
    {s0_valid, s1_valid, m_ready, t_s0_valid, t_s1_valid, t_m_ready} = '0;
    s0_data = '0; s1_data = '0; t_s0_data = '0; t_s1_data = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    q.delete();
  endtask

  task automatic check_block(input int base, input logic [DW-1:0] d0, input logic id);
    logic [DW+1:0] e;
    for (int i = 0; i < 4; i++) begin
      checks++;
      e = (base + i < q.size()) ? q[base + i] : '1;
      if (e !== {id, i == 3, d0 + DW'(i)}) begin
        errs++;
        $display("FAIL beat%0d: got id=%0b last=%0b data=%h, want id=%0b last=%0b data=%h",
                 base + i, e[DW+1], e[DW], e[DW-1:0], id, i == 3, d0 + DW'(i));
      end
    end
  endtask

  task automatic test_reset();
    reset = 0;
    #3;
    checks++;
    if ({m_valid, m_data, m_id, m_last, busy, grant, s0_ready, s1_ready} !== '0) begin
      errs++;
      $display("FAIL reset_outputs: got v=%0b d=%h id=%0b l=%0b busy=%0b g=%0b r0=%0b r1=%0b, want all 0",
               m_valid, m_data, m_id, m_last, busy, grant, s0_ready, s1_ready);
    end
  endtask

  task automatic test_single();
    int n = 0, cyc = 0;
    apply_reset();
    s0_valid = 1; s0_data = 'h10; m_ready = 1;
    checks++;
    if (busy !== 0 || s0_ready !== 0) begin errs++; $display("FAIL single_idle: busy=%0b r0=%0b, want 0 0", busy, s0_ready); end
    step();
    checks++;
    if (grant !== 0 || busy !== 1) begin errs++; $display("FAIL single_grant: grant=%0b busy=%0b, want 0 1", grant, busy); end
    while (n < 4 && cyc < 20) begin
      step(); cyc++;
      if (a0) begin n++; s0_data = 'h10 + DW'(n); end
    end
    checks++;
    if (cyc !== 4) begin errs++; $display("FAIL single_accept_cycles: got %0d, want 4", cyc); end
    checks++;
    if (busy !== 0) begin errs++; $display("FAIL single_busy_end: busy=%0b, want 0", busy); end
    s0_valid = 0;
    repeat (3) step();
    checks++;
    if (q.size() !== 4) begin errs++; $display("FAIL single_count: got %0d beats, want 4", q.size()); end
    check_block(0, 'h10, 0);
  endtask

  task automatic test_back_to_back();
    int n = 0, idle = 0, cyc = 0;
    apply_reset();
    s0_valid = 1; s1_valid = 1; s0_data = 'hA0; s1_data = 'hB0; m_ready = 1;
    while (n < 16 && cyc < 200) begin
      step(); cyc++;
      if (a0) begin n++; s0_data++; end
      if (a1) begin n++; s1_data++; end
      if (!a0 && !a1) idle++;
    end
    checks++;
    if (idle !== 4) begin errs++; $display("FAIL b2b_idle: got %0d idle cycles, want 4", idle); end
    s0_valid = 0; s1_valid = 0;
    repeat (3) step();
    checks++;
    if (q.size() !== 16) begin errs++; $display("FAIL b2b_count: got %0d beats, want 16", q.size()); end
    check_block(0, 'hA0, 0);
    check_block(4, 'hB0, 1);
    check_block(8, 'hA4, 0);
    check_block(12, 'hB4, 1);
  endtask

  task automatic test_backpressure();
    int n = 0, cyc = 0;
    apply_reset();
    s0_valid = 1; s0_data = 'h10; m_ready = 1;
    while (n < 2 && cyc < 20) begin
      step(); cyc++;
      if (a0) begin n++; s0_data = 'h10 + DW'(n); end
    end
    m_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (s0_ready !== 0 || a0 !== 0 || m_valid !== 1 || m_data !== 'h11 || m_id !== 0 || m_last !== 0) begin
        errs++;
        $display("FAIL bp_hold%0d: r0=%0b acc=%0b v=%0b d=%h id=%0b l=%0b, want 0 0 1 11 0 0",
                 i, s0_ready, a0, m_valid, m_data, m_id, m_last);
      end
    end
    m_ready = 1;
    while (n < 4 && cyc < 40) begin
      step(); cyc++;
      if (a0) begin n++; s0_data = 'h10 + DW'(n); end
    end
    s0_valid = 0;
    repeat (3) step();
    checks++;
    if (q.size() !== 4) begin errs++; $display("FAIL bp_count: got %0d beats, want 4", q.size()); end
    check_block(0, 'h10, 0);
  endtask

  task automatic test_drop_valid();
    int n = 0, cyc = 0;
    apply_reset();
    s1_valid = 1; s1_data = 'hB0; m_ready = 1;
    step();
    checks++;
    if (grant !== 1 || busy !== 1) begin errs++; $display("FAIL drop_grant1: grant=%0b busy=%0b, want 1 1", grant, busy); end
    s0_valid = 1; s0_data = 'hA0;
    while (n < 2 && cyc < 20) begin
      step(); cyc++;
      if (a1) begin n++; s1_data = 'hB0 + DW'(n); end
    end
    s1_valid = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (s0_ready !== 0 || a0 !== 0 || busy !== 1 || grant !== 1) begin
        errs++;
        $display("FAIL drop_hold%0d: r0=%0b acc0=%0b busy=%0b grant=%0b, want 0 0 1 1", i, s0_ready, a0, busy, grant);
      end
    end
    s1_valid = 1;
    while (n < 4 && cyc < 40) begin
      step(); cyc++;
      if (a1) begin n++; s1_data = 'hB0 + DW'(n); end
      if (a0) begin errs++; $display("FAIL drop_s0_leak: got s0 accept, want none"); end
    end
    s1_valid = 0;
    step();
    checks++;
    if (grant !== 0 || busy !== 1) begin errs++; $display("FAIL drop_grant0: grant=%0b busy=%0b, want 0 1", grant, busy); end
    s0_valid = 0;
    repeat (3) step();
    checks++;
    if (q.size() !== 4) begin errs++; $display("FAIL drop_count: got %0d beats, want 4", q.size()); end
    check_block(0, 'hB0, 1);
  endtask

  task automatic test_mid_reset();
    int n = 0, cyc = 0;
    apply_reset();
    s0_valid = 1; s1_valid = 1; s0_data = 'hA0; s1_data = 'hB0; m_ready = 1;
    while (n < 6 && cyc < 40) begin
      step(); cyc++;
      if (a0) begin n++; s0_data++; end
      if (a1) begin n++; s1_data++; end
    end
    #2 reset = 0;
    #1;
    checks++;
    if ({m_valid, m_data, m_id, m_last, busy, grant, s0_ready, s1_ready} !== '0) begin
      errs++;
      $display("FAIL midreset_outputs: got v=%0b d=%h id=%0b l=%0b busy=%0b g=%0b r0=%0b r1=%0b, want all 0",
               m_valid, m_data, m_id, m_last, busy, grant, s0_ready, s1_ready);
    end
    @(posedge clk);
    #1 reset = 1;
    q.delete();
    n = 0; cyc = 0;
    step();
    checks++;
    if (grant !== 0 || busy !== 1) begin errs++; $display("FAIL midreset_grant: grant=%0b busy=%0b, want 0 1", grant, busy); end
    while (n < 4 && cyc < 20) begin
      step(); cyc++;
      if (a0) begin n++; s0_data++; end
      if (a1) begin n++; s1_data++; end
    end
    s0_valid = 0; s1_valid = 0;
    repeat (3) step();
    checks++;
    if (q.size() !== 4) begin errs++; $display("FAIL midreset_count: got %0d beats, want 4", q.size()); end
    check_block(0, 'hA4, 0);
  endtask

  task automatic test_block_len1();
    int k = 0, cyc = 0;
    apply_reset();
    t_s0_valid = 1; t_s1_valid = 1; t_s0_data = 'hC0; t_s1_data = 'hD0; t_m_ready = 1;
    while (k < 6 && cyc < 60) begin
      @(negedge clk); cyc++;
      if (t_m_valid && t_m_ready) begin
        checks++;
        if (t_m_last !== 1 || t_m_id !== k[0] || t_m_data !== (k[0] ? DW'('hD0) : DW'('hC0))) begin
          errs++;
          $display("FAIL bl1_beat%0d: id=%0b last=%0b data=%h, want id=%0b last=1 data=%h",
                   k, t_m_id, t_m_last, t_m_data, k[0], k[0] ? DW'('hD0) : DW'('hC0));
        end
        k++;
      end
    end
    checks++;
    if (k !== 6) begin errs++; $display("FAIL bl1_count: got %0d beats, want 6", k); end
    @(posedge clk);
    #1;
  endtask

  initial begin
    {s0_valid, s1_valid, m_ready, t_s0_valid, t_s1_valid, t_m_ready} = '0;
    s0_data = '0; s1_data = '0; t_s0_data = '0; t_s1_data = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_drop_valid();
    test_mid_reset();
    test_block_len1();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
